// File: rtl/counter_history_display.sv
// counter_history_display
//   Records the last four distinct values of an upstream 4-bit display counter
//   and counts F->0 wrap-arounds as a two-digit BCD number.
//   Drives six 7-segment displays.
// Ports:
//   ClockIn      system clock, shared with the upstream counter
//   Reset        asynchronous active-low reset
//   CounterValue value sampled from the upstream counter every cycle
//   Freeze       holds the history and the wrap count; change tracking continues
//   ChangePulse  one-cycle pulse after a value has been recorded
//   Overflow     sticky flag, set when the wrap count rolls from 99 to 00
//   HEX0..HEX3   history digits, HEX0 newest (bit0 = seg a .. bit6 = seg g)
//   HEX4, HEX5   wrap count units and tens digits
module counter_history_display #(
  parameter bit BLANK_EMPTY    = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic [3:0] CounterValue,
  input  logic       Freeze,
  output logic       ChangePulse,
  output logic       Overflow,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  // Returns the active-low glyph for one hex digit.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Converts an active-low segment pattern to the configured output polarity.
  function automatic logic [6:0] polarity(input logic [6:0] seg_low);
    return SEG_ACTIVE_LOW ? seg_low : ~seg_low;
  endfunction

  // Active-low pattern for one history slot, honouring the empty-slot style.
  function automatic logic [6:0] hist_seg(input logic v, input logic [3:0] d);
    logic [6:0] g;
    if (v) begin
      g = glyph(d);
    end else if (BLANK_EMPTY) begin
      g = 7'h7F;
    end else begin
      g = glyph(4'h0);
    end
    return g;
  endfunction

  logic [3:0] prev_value;
  logic [3:0] hist [4];
  logic [3:0] valid;
  logic [3:0] units;
  logic [3:0] tens;

  logic       change;
  logic       record;
  logic       wrap;
  logic [3:0] units_next;
  logic [3:0] tens_next;
  logic       overflow_next;

  // Change detection and BCD increment of the wrap count.
  always_comb begin
    change        = (CounterValue != prev_value);
    record        = change && !Freeze;
    // Only a genuine F->0 step counts; any other jump is history only.
    wrap          = record && (prev_value == 4'hF) && (CounterValue == 4'h0);
    units_next    = units;
    tens_next     = tens;
    overflow_next = Overflow;
    if (wrap) begin
      if (units == 4'd9) begin
        units_next = 4'd0;
        if (tens == 4'd9) begin
          tens_next     = 4'd0;
          overflow_next = 1'b1;
        end else begin
          tens_next = tens + 4'd1;
        end
      end else begin
        units_next = units + 4'd1;
      end
    end else begin
      units_next = units;
    end
  end

  // State registers: previous sample, history shift chain, wrap count, flags.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      prev_value  <= 4'h0;
      hist[0]     <= 4'h0;
      hist[1]     <= 4'h0;
      hist[2]     <= 4'h0;
      hist[3]     <= 4'h0;
      valid       <= 4'b0000;
      units       <= 4'd0;
      tens        <= 4'd0;
      Overflow    <= 1'b0;
      ChangePulse <= 1'b0;
    end else begin
      // PrevValue tracks the input even while frozen, so a change made during
      // Freeze is never recorded after Freeze falls.
      prev_value  <= CounterValue;
      ChangePulse <= record;
      units       <= units_next;
      tens        <= tens_next;
      Overflow    <= overflow_next;
      if (record) begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= CounterValue;
        valid   <= {valid[2:0], 1'b1};
      end
    end
  end

  // Display decode straight from registered state.
  always_comb begin
    HEX0 = polarity(hist_seg(valid[0], hist[0]));
    HEX1 = polarity(hist_seg(valid[1], hist[1]));
    HEX2 = polarity(hist_seg(valid[2], hist[2]));
    HEX3 = polarity(hist_seg(valid[3], hist[3]));
    HEX4 = polarity(glyph(units));
    HEX5 = polarity(glyph(tens));
  end

endmodule

// File: doc/counter_history_display.md
Name: counter_history_display

Overview:
- Sits directly downstream of the rate-divided 4-bit display counter. Consumes its CounterValue and drives the board's six 7-segment displays.
- HEX3..HEX0 show the last four distinct counter values; HEX0 is the newest.
- HEX5..HEX4 show a two-digit BCD count of F->0 wrap-arounds.
- Fully synchronous to the counter's clock; no handshake with the upstream counter beyond sampling its output every cycle.

Parameters:
- BLANK_EMPTY, 1, 1 = history digits with no recorded value are blanked; 0 = they show "0".
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (lit segment = 0); 0 = active-high.

Ports:
- ClockIn  input  1  system clock, same clock as the upstream counter.
- Reset  input  1  asynchronous, active-low reset.
- CounterValue  input  4  value from the upstream display counter; synchronous to ClockIn.
- Freeze  input  1  when 1, history and wrap count hold; change tracking continues.
- ChangePulse  output  1  one-cycle pulse; a new value was recorded.
- Overflow  output  1  sticky; wrap count rolled past 99.
- HEX0, HEX1, HEX2, HEX3, HEX4, HEX5  output  7 each  segment drives; bit0 = seg a ... bit6 = seg g.

Behaviour:
- Reset is asynchronous, active-low. While Reset = 0:
  - PrevValue = 0; History H0..H3 = 0; Valid[3:0] = 0.
  - WrapCount tens/units = 0/0; Overflow = 0; ChangePulse = 0.
  - Reset release mid-operation needs no special handling; a counter value other than 0 at the first edge is treated as a change.
- PrevValue <= CounterValue on every rising edge, regardless of Freeze.
- Change = (CounterValue != PrevValue), evaluated on the pre-edge values.
- On an edge with Change = 1 and Freeze = 0:
  - Shift: H3 <= H2, H2 <= H1, H1 <= H0, H0 <= CounterValue.
  - Valid <= {Valid[2:0], 1}.
  - ChangePulse <= 1 for exactly the next cycle. Consecutive changes give consecutive pulses.
- On an edge with Change = 1 and Freeze = 1: nothing recorded, ChangePulse <= 0. After Freeze falls, the value that changed during Freeze is not recorded retroactively.
- Wrap: a wrap is counted only when PrevValue = 4'hF and CounterValue = 4'h0 on a recorded change.
  - Any other jump (e.g. E->1, F->3) is recorded in history but does not count as a wrap.
- WrapCount is two BCD digits:
  - Units 9 -> 0 carries into tens.
  - 99 -> 00 sets Overflow = 1. Overflow stays set until Reset.
  - Neither digit ever holds a value above 9.
- Display decode is combinational from registered state, so a new value is visible on HEX0 right after the recording edge (0 cycles after state update).
  - Digit map, standard 0-F glyphs, active-low: 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03, C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E.
  - SEG_ACTIVE_LOW = 0 inverts all seven bits.
  - HEXn for n = 0..3 shows Hn if Valid[n] = 1. Otherwise it is blank (7'h7F active-low) when BLANK_EMPTY = 1, or the glyph "0" when BLANK_EMPTY = 0.
  - HEX4 = units digit, HEX5 = tens digit; never blanked.
- Simultaneous wrap and Freeze: Freeze wins; no history update, no wrap count.
- Upstream holding a constant value: no state change, ChangePulse stays 0.

Test Plan:
1. Reset low, then release with CounterValue = 0 held for 10 cycles -> HEX0..HEX3 = 7'h7F, HEX4 = HEX5 = 7'h40, ChangePulse never 1.
2. Drive 1, 2, 3, 4, 5, one per 3 cycles -> HEX0..HEX3 = 5, 4, 3, 2 glyphs (7'h12, 7'h19, 7'h30, 7'h24); exactly 5 single-cycle ChangePulses, each one cycle after the change.
3. Sweep 0->F->0 sixteen times -> HEX5/HEX4 = "1"/"6" (7'h79/7'h02); a 5->7 jump records 7 with no wrap count; an E->0 jump is not counted.
4. Force 100 F->0 transitions -> WrapCount shows 00, Overflow = 1 and stays 1 after 20 more wraps until Reset.
5. Freeze = 1, change 3->9, Freeze = 0, hold 9 -> history unchanged, no ChangePulse; a following 9->A records A only.
6. Assert Reset low asynchronously mid-sweep, between edges -> all outputs reach their reset values immediately without a clock edge; WrapCount = 00, HEX0..HEX3 blank.
